// File: rtl/video_out.sv
// Video output stage: pixel-rate divider, H/V counters, blank/sync timing and
// a two-stage pixel pipeline that expands IRGB4444 to intensity-scaled RGB888.
module video_out #(
    parameter int CLK_DIV  = 2,
    parameter int H_TOTAL  = 456,
    parameter int H_ACTIVE = 336,
    parameter int HS_START = 368,
    parameter int HS_END   = 400,
    parameter int V_TOTAL  = 262,
    parameter int V_ACTIVE = 240,
    parameter int VS_START = 244,
    parameter int VS_END   = 247
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] D,
    output logic        PIX_EN,
    output logic [8:0]  HPOS,
    output logic [8:0]  VPOS,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic        HSYNC_b,
    output logic        VSYNC_b,
    output logic        BLANK_b
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
    localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);
    localparam logic [8:0] HS_S   = 9'(HS_START);
    localparam logic [8:0] HS_E   = 9'(HS_END);
    localparam logic [8:0] VS_S   = 9'(VS_START);
    localparam logic [8:0] VS_E   = 9'(VS_END);

    logic [DW-1:0] div_q, div_d;
    logic          pix_en_q, pix_en_d;
    logic [8:0]    hpos_q, hpos_d;
    logic [8:0]    vpos_q, vpos_d;
    logic [15:0]   s1_dat_q, s1_dat_d;
    logic          s1_act_q, s1_act_d;
    logic          s1_hs_q, s1_hs_d;
    logic          s1_vs_q, s1_vs_d;
    logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
    logic          hsync_b_q, hsync_b_d;
    logic          vsync_b_q, vsync_b_d;
    logic          blank_b_q, blank_b_d;

    logic          active, hs, vs;
    logic [4:0]    i_p1;
    logic [7:0]    r_mul, g_mul, b_mul;

    always_comb begin
        active = (hpos_q < H_ACT) && (vpos_q < V_ACT);
        hs     = (hpos_q >= HS_S) && (hpos_q < HS_E);
        vs     = (vpos_q >= VS_S) && (vpos_q < VS_E);

        // Intensity I selects a gain of I+1, so I=0 is dim rather than black.
        i_p1  = {1'b0, s1_dat_q[15:12]} + 5'd1;
        r_mul = {4'd0, s1_dat_q[11:8]} * {3'd0, i_p1};
        g_mul = {4'd0, s1_dat_q[7:4]}  * {3'd0, i_p1};
        b_mul = {4'd0, s1_dat_q[3:0]}  * {3'd0, i_p1};

        div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        pix_en_d  = (div_q == DIV_LAST);
        hpos_d    = hpos_q;
        vpos_d    = vpos_q;
        s1_dat_d  = s1_dat_q;
        s1_act_d  = s1_act_q;
        s1_hs_d   = s1_hs_q;
        s1_vs_d   = s1_vs_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        hsync_b_d = hsync_b_q;
        vsync_b_d = vsync_b_q;
        blank_b_d = blank_b_q;

        if (pix_en_q) begin
            if (hpos_q == H_LAST) begin
                hpos_d = '0;
                vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 9'd1;
            end else begin
                hpos_d = hpos_q + 9'd1;
            end

            s1_dat_d = D;
            s1_act_d = active;
            s1_hs_d  = hs;
            s1_vs_d  = vs;

            r_d       = s1_act_q ? r_mul : 8'd0;
            g_d       = s1_act_q ? g_mul : 8'd0;
            b_d       = s1_act_q ? b_mul : 8'd0;
            blank_b_d = s1_act_q;
            hsync_b_d = ~s1_hs_q;
            vsync_b_d = ~s1_vs_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            pix_en_q  <= 1'b0;
            hpos_q    <= '0;
            vpos_q    <= '0;
            s1_dat_q  <= '0;
            s1_act_q  <= 1'b0;
            s1_hs_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            hsync_b_q <= 1'b1;
            vsync_b_q <= 1'b1;
            blank_b_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            pix_en_q  <= pix_en_d;
            hpos_q    <= hpos_d;
            vpos_q    <= vpos_d;
            s1_dat_q  <= s1_dat_d;
            s1_act_q  <= s1_act_d;
            s1_hs_q   <= s1_hs_d;
            s1_vs_q   <= s1_vs_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hsync_b_q <= hsync_b_d;
            vsync_b_q <= vsync_b_d;
            blank_b_q <= blank_b_d;
        end
    end

    assign PIX_EN  = pix_en_q;
    assign HPOS    = hpos_q;
    assign VPOS    = vpos_q;
    assign R       = r_q;
    assign G       = g_q;
    assign B       = b_q;
    assign HSYNC_b = hsync_b_q;
    assign VSYNC_b = vsync_b_q;
    assign BLANK_b = blank_b_q;

endmodule

// File: tb/tb_video_out.sv
// Bench for video_out on a reduced raster so several full frames fit in a short run.
module tb_video_out;

    localparam int CD  = 2;
    localparam int HT  = 20;
    localparam int HA  = 12;
    localparam int HSS = 14;
    localparam int HSE = 17;
    localparam int VT  = 10;
    localparam int VA  = 6;
    localparam int VSS = 7;
    localparam int VSE = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d   = '0;
    logic        PIX_EN;
    logic [8:0]  HPOS, VPOS;
    logic [7:0]  R, G, B;
    logic        HSYNC_b, VSYNC_b, BLANK_b;

    video_out #(
        .CLK_DIV(CD), .H_TOTAL(HT), .H_ACTIVE(HA), .HS_START(HSS), .HS_END(HSE),
        .V_TOTAL(VT), .V_ACTIVE(VA), .VS_START(VSS), .VS_END(VSE)
    ) dut (
        .clk(clk), .rst(rst), .D(d), .PIX_EN(PIX_EN), .HPOS(HPOS), .VPOS(VPOS),
        .R(R), .G(G), .B(B), .HSYNC_b(HSYNC_b), .VSYNC_b(VSYNC_b), .BLANK_b(BLANK_b)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: edges since reset release, pixels consumed, last sampled word.
    int          edges = 0;
    int          p     = 0;
    logic [15:0] d_last = '0;
    bit          pix_edge = 0;
    int          e_pix = 0, e_r = 0, e_g = 0, e_b = 0;
    int          e_hs = 1, e_vs = 1, e_blank = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_out(input logic [15:0] w, input int idx);
        int h, v, k;
        bit act;
        h   = idx % HT;
        v   = (idx / HT) % VT;
        act = (h < HA) && (v < VA);
        k   = int'(w[15:12]) + 1;
        e_r     = act ? int'(w[11:8]) * k : 0;
        e_g     = act ? int'(w[7:4]) * k : 0;
        e_b     = act ? int'(w[3:0]) * k : 0;
        e_blank = act ? 1 : 0;
        e_hs    = (h >= HSS && h < HSE) ? 0 : 1;
        e_vs    = (v >= VSS && v < VSE) ? 0 : 1;
    endtask

    task automatic model_edge(input logic r, input logic [15:0] dv);
        int np;
        pix_edge = 0;
        if (r) begin
            edges = 0;
            p = 0;
            e_r = 0; e_g = 0; e_b = 0; e_blank = 0; e_hs = 1; e_vs = 1;
        end else begin
            edges++;
            np = (edges - 1) / CD;
            if (np != p) begin
                pix_edge = 1;
                if (np >= 2) set_out(d_last, np - 2);
                d_last = dv;
                p = np;
            end
        end
        e_pix = (!r && edges >= 1 && ((edges - 1) % CD) == CD - 1) ? 1 : 0;
    endtask

    task automatic step(input logic r, input logic [15:0] dv);
        @(negedge clk);
        rst = r;
        d   = dv;
        @(posedge clk);
        model_edge(r, dv);
        #1;
        chk("pix_en", PIX_EN, e_pix);
        chk("hpos", HPOS, p % HT);
        chk("vpos", VPOS, (p / HT) % VT);
        chk("r", R, e_r);
        chk("g", G, e_g);
        chk("b", B, e_b);
        chk("hsync_b", HSYNC_b, e_hs);
        chk("vsync_b", VSYNC_b, e_vs);
        chk("blank_b", BLANK_b, e_blank);
    endtask

    initial begin
        int nframes, pix_cnt, hs_lo, vs_lo, bl_hi, oidx, oh, ov;
        bit found;
        logic [15:0] dv;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom));
        chk("rst_r", R, 0);
        chk("rst_blank_b", BLANK_b, 0);
        chk("rst_hsync_b", HSYNC_b, 1);
        chk("rst_vsync_b", VSYNC_b, 1);

        // First pixel enable two cycles after release, then every other cycle
        step(1'b0, 16'($urandom));
        chk("first_pix_lo", PIX_EN, 0);
        step(1'b0, 16'($urandom));
        chk("first_pix_hi", PIX_EN, 1);
        step(1'b0, 16'($urandom));
        chk("second_pix_lo", PIX_EN, 0);

        // Frame 0 random with scaling points, frame 1 all-white, then a bit more
        nframes = 0; pix_cnt = 0; hs_lo = 0; vs_lo = 0; bl_hi = 0;
        for (int n = 0; n < 3000 && p < 2 * HT * VT + 5; n++) begin
            dv = 16'($urandom);
            if (p >= HT * VT && p < 2 * HT * VT) dv = 16'hFFFF;
            else if (p % HT == 10 && (p / HT) % VT == 5) dv = 16'hFF81;
            else if (p % HT == 11 && (p / HT) % VT == 5) dv = 16'h0F00;
            step(1'b0, dv);
            if (PIX_EN === 1'b1) pix_cnt++;
            if (pix_edge && p >= 2) begin
                oidx = p - 2;
                oh = oidx % HT;
                ov = (oidx / HT) % VT;
                if (oidx < HT * VT && oh == 10 && ov == 5) begin
                    chk("scale_r", R, 240);
                    chk("scale_g", G, 128);
                    chk("scale_b", B, 16);
                    chk("scale_blank_b", BLANK_b, 1);
                end
                if (oidx < HT * VT && oh == 11 && ov == 5) begin
                    chk("dim_r", R, 15);
                    chk("dim_g", G, 0);
                    chk("dim_b", B, 0);
                end
                if (oidx >= HT * VT && oidx < 2 * HT * VT) begin
                    if (oh == HA && ov == 0) chk("white_hblank_r", R, 0);
                    if (oh == 0 && ov == VA) chk("white_vblank_blank_b", BLANK_b, 0);
                    if (oh == HA - 1 && ov == 1) chk("white_active_r", R, 240);
                end
            end
            if (pix_edge) begin
                if (HSYNC_b === 1'b0) hs_lo++;
                if (VSYNC_b === 1'b0) vs_lo++;
                if (BLANK_b === 1'b1) bl_hi++;
                if (HPOS === 9'd0 && VPOS === 9'd0) begin
                    if (nframes > 0) begin
                        chk("frame_pix_en_count", pix_cnt, HT * VT);
                        chk("frame_hsync_low_count", hs_lo, (HSE - HSS) * VT);
                        chk("frame_vsync_low_count", vs_lo, (VSE - VSS) * HT);
                        chk("frame_active_count", bl_hi, HA * VA);
                    end
                    nframes++;
                    pix_cnt = 0; hs_lo = 0; vs_lo = 0; bl_hi = 0;
                end
            end
        end
        chk("frames_seen", nframes, 2);

        // Reset mid-line, inside hsync, on a cycle where PIX_EN is also high
        found = 0;
        for (int n = 0; n < 1000 && !found; n++) begin
            if (p % HT == 16 && (p / HT) % VT == 4 && e_pix == 1) found = 1;
            else step(1'b0, 16'($urandom));
        end
        chk("find_reset_point", found, 1);
        chk("pre_reset_hsync_b", HSYNC_b, 0);
        step(1'b1, 16'hFFFF);
        chk("midrst_pix_en", PIX_EN, 0);
        chk("midrst_hpos", HPOS, 0);
        chk("midrst_vpos", VPOS, 0);
        chk("midrst_r", R, 0);
        chk("midrst_blank_b", BLANK_b, 0);
        chk("midrst_hsync_b", HSYNC_b, 1);
        chk("midrst_vsync_b", VSYNC_b, 1);
        for (int n = 0; n < 120; n++) step(1'b0, 16'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
